// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI burst/response encodings and channel field widths
package axi_pkg;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'd0;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'd1;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'd2;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
    localparam logic [1:0] AXI_RESP_DECERR = 2'd3;
    typedef enum logic {ST_IDLE, ST_BURST} rd_state_e;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [AXI_SIZE_W-1:0]  size,
    input  logic [AXI_LEN_W-1:0]   len,
    input  logic [AXI_BURST_W-1:0] burst,
    output logic [ADDR_WIDTH-1:0]  next_addr
);
    logic [ADDR_WIDTH-1:0] step, mask, wrap_addr;
    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        mask      = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        wrap_addr = (addr & ~mask) | ((addr + step) & mask);
        next_addr = burst == AXI_BURST_INCR ? addr + step :
                    burst == AXI_BURST_WRAP ? wrap_addr : addr;
    end
endmodule

// File: rtl/axi_rd_mem.sv
// axi_rd_mem: AXI4 read-only memory slave with bursts, error responses and a preload port
module axi_rd_mem
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ID_WIDTH-1:0]            axi_slv_arid,
    input  logic [ADDR_WIDTH-1:0]          axi_slv_araddr,
    input  logic [AXI_LEN_W-1:0]           axi_slv_arlen,
    input  logic [AXI_SIZE_W-1:0]          axi_slv_arsize,
    input  logic [AXI_BURST_W-1:0]         axi_slv_arburst,
    input  logic                           axi_slv_arlock,
    input  logic [3:0]                     axi_slv_arcache,
    input  logic [2:0]                     axi_slv_arprot,
    input  logic [3:0]                     axi_slv_arqos,
    input  logic [3:0]                     axi_slv_arregion,
    input  logic                           axi_slv_arvalid,
    output logic                           axi_slv_arready,
    output logic [ID_WIDTH-1:0]            axi_slv_rid,
    output logic [DATA_WIDTH-1:0]          axi_slv_rdata,
    output logic [1:0]                     axi_slv_rresp,
    output logic                           axi_slv_rlast,
    output logic                           axi_slv_rvalid,
    input  logic                           axi_slv_rready,
    input  logic                           init_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] init_idx,
    input  logic [DATA_WIDTH-1:0]          init_wdata
);
    localparam int OFF   = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) * 64'(DATA_WIDTH / 8);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    rd_state_e              state_q, state_d;
    logic                   arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic                   slverr_q, slverr_d;
    logic [ID_WIDTH-1:0]    id_q, id_d, rid_q, rid_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [AXI_LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d;
    logic [AXI_SIZE_W-1:0]  size_q, size_d;
    logic [AXI_BURST_W-1:0] burst_q, burst_d;
    logic [1:0]             rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

    logic                   ar_hs, r_hs, new_slverr, iss_slverr, in_range;
    logic [ADDR_WIDTH-1:0]  next_addr, iss_addr, off;
    logic [1:0]             iss_resp;
    logic [DATA_WIDTH-1:0]  iss_data;
    logic                   unused_ok;

    assign unused_ok = ^{axi_slv_arlock, axi_slv_arcache, axi_slv_arprot,
                         axi_slv_arqos, axi_slv_arregion, off};

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    always_ff @(posedge clk) begin
        if (init_we) mem[init_idx] <= init_wdata;
    end

    always_comb begin
        state_d    = state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        slverr_d   = slverr_q;
        id_d       = id_q;
        rid_d      = rid_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        burst_d    = burst_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        ar_hs      = state_q == ST_IDLE && axi_slv_arvalid && arready_q;
        r_hs       = rvalid_q && axi_slv_rready;
        new_slverr = axi_slv_arsize > AXI_SIZE_W'(OFF) || axi_slv_arburst == 2'd3 ||
                     (axi_slv_arburst == AXI_BURST_WRAP &&
                      !(axi_slv_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
        // Address and error status of the beat about to be read, whichever path issues it
        iss_addr   = ar_hs ? axi_slv_araddr : next_addr;
        iss_slverr = ar_hs ? new_slverr : slverr_q;
        off        = iss_addr - BASE_ADDR;
        in_range   = iss_addr >= BASE_ADDR && 64'(off) < SPAN;
        iss_resp   = iss_slverr ? AXI_RESP_SLVERR : in_range ? AXI_RESP_OKAY : AXI_RESP_DECERR;
        iss_data   = iss_resp == AXI_RESP_OKAY ? mem[off[OFF +: IDX_W]] : '0;
        if (ar_hs) begin
            state_d   = ST_BURST;
            arready_d = 1'b0;
            id_d      = axi_slv_arid;
            addr_d    = axi_slv_araddr;
            len_d     = axi_slv_arlen;
            size_d    = axi_slv_arsize;
            burst_d   = axi_slv_arburst;
            slverr_d  = new_slverr;
            cnt_d     = '0;
            rvalid_d  = 1'b1;
            rlast_d   = axi_slv_arlen == '0;
            rid_d     = axi_slv_arid;
            rresp_d   = iss_resp;
            rdata_d   = iss_data;
        end else if (state_q == ST_BURST && r_hs) begin
            state_d   = rlast_q ? ST_IDLE : ST_BURST;
            arready_d = rlast_q;
            rvalid_d  = !rlast_q;
            rlast_d   = !rlast_q && cnt_q + 8'd1 == len_q;
            addr_d    = rlast_q ? addr_q : next_addr;
            cnt_d     = rlast_q ? cnt_q : cnt_q + 8'd1;
            rresp_d   = rlast_q ? rresp_q : iss_resp;
            rdata_d   = rlast_q ? rdata_q : iss_data;
        end else if (state_q == ST_IDLE) begin
            arready_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            slverr_q  <= 1'b0;
            id_q      <= '0;
            rid_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            slverr_q  <= slverr_d;
            id_q      <= id_d;
            rid_q     <= rid_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign axi_slv_arready = arready_q;
    assign axi_slv_rvalid  = rvalid_q;
    assign axi_slv_rlast   = rlast_q;
    assign axi_slv_rid     = rid_q;
    assign axi_slv_rresp   = rresp_q;
    assign axi_slv_rdata   = rdata_q;
endmodule

// File: tb/tb_axi_rd_mem.sv
// tb_axi_rd_mem: directed bench with a queue-based burst model checked every cycle
module tb_axi_rd_mem;
    localparam longint unsigned BASE = 64'h4000_0000;
    localparam longint unsigned SPAN = 64'd4096;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        init_we;
    logic [9:0]  init_idx;
    logic [31:0] init_wdata;

    int          total = 0, bad = 0;
    logic [31:0] mdl [1024];
    beat_t       exp_q[$], obs[$];
    logic        last_rst = 1'b1;
    logic        rr_toggle = 1'b0;

    always #5 clk = ~clk;

    axi_rd_mem dut (
        .clk(clk), .rst(rst),
        .axi_slv_arid(arid), .axi_slv_araddr(araddr), .axi_slv_arlen(arlen),
        .axi_slv_arsize(arsize), .axi_slv_arburst(arburst),
        .axi_slv_arlock(1'b0), .axi_slv_arcache(4'd0), .axi_slv_arprot(3'd0),
        .axi_slv_arqos(4'd0), .axi_slv_arregion(4'd0),
        .axi_slv_arvalid(arvalid), .axi_slv_arready(arready),
        .axi_slv_rid(rid), .axi_slv_rdata(rdata), .axi_slv_rresp(rresp),
        .axi_slv_rlast(rlast), .axi_slv_rvalid(rvalid), .axi_slv_rready(rready),
        .init_we(init_we), .init_idx(init_idx), .init_wdata(init_wdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Model: expand each accepted request into its full list of beats from byte addresses
    initial begin : model
        longint unsigned a0, nb, bytes, a;
        bit    slv;
        beat_t b;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("arready", arready, !last_rst && exp_q.size() == 0);
            if (exp_q.size() == 0) chk("rvalid_idle", rvalid, 0);
            else begin
                chk("rvalid", rvalid, 1);
                if (rvalid) begin
                    chk("rid", rid, exp_q[0].id);
                    chk("rdata", rdata, exp_q[0].data);
                    chk("rresp", rresp, exp_q[0].resp);
                    chk("rlast", rlast, exp_q[0].last);
                    if (rready) begin
                        obs.push_back({rid, rdata, rresp, rlast});
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (rst) exp_q.delete();
            if (init_we) mdl[init_idx] = init_wdata;
            if (arvalid && arready && !rst) begin
                a0    = araddr;
                nb    = 64'd1 << arsize;
                bytes = (longint'(arlen) + 1) * nb;
                slv   = arsize > 2 || arburst == 3 ||
                        (arburst == 2 && !(arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
                for (int i = 0; i <= int'(arlen); i++) begin
                    a = arburst == 0 ? a0 :
                        arburst == 2 ? (a0 / bytes) * bytes + (a0 % bytes + i * nb) % bytes :
                        a0 + i * nb;
                    b.id   = arid;
                    b.last = i == int'(arlen);
                    if (slv) begin
                        b.data = 0; b.resp = 2;
                    end else if (a >= BASE && a < BASE + SPAN) begin
                        b.data = mdl[int'((a - BASE) / 4)]; b.resp = 0;
                    end else begin
                        b.data = 0; b.resp = 3;
                    end
                    exp_q.push_back(b);
                end
            end
            last_rst = rst;
        end
    end

    initial begin
        rready = 1'b1;
        forever begin
            @(posedge clk);
            #1 rready = rr_toggle ? ~rready : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic preload(input int idx, input logic [31:0] d);
        init_we = 1'b1; init_idx = 10'(idx); init_wdata = d;
        @(posedge clk); #1;
        init_we = 1'b0;
    endtask

    task automatic ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                      input logic [2:0] sz, input logic [1:0] bt);
        bit hs = 0;
        arvalid = 1'b1; arid = id; araddr = a; arlen = len; arsize = sz; arburst = bt;
        for (int k = 0; k < 20 && !hs; k++) begin
            @(negedge clk); hs = arready;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        if (!hs) chk("ar_timeout", 0, 1);
    endtask

    task automatic drain;
        bit done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(posedge clk); #2;
            done = exp_q.size() == 0 && !rvalid;
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0;
        arburst = '0; init_we = 1'b0; init_idx = '0; init_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) preload(i, 32'h1000_0000 + 32'(i * 4));
        preload(5, 32'hDEAD_BEEF);
        preload(1023, 32'hCAFE_F00D);

        obs.delete();
        ar(4'd3, 32'h4000_0014, 8'd0, 3'd2, 2'd1);
        chk("single_latency", rvalid, 1);
        drain();
        chk("single_n", obs.size(), 1);
        chk("single_data", obs[0].data, 32'hDEAD_BEEF);
        chk("single_id", obs[0].id, 3);
        chk("single_resp", obs[0].resp, 0);
        chk("single_last", obs[0].last, 1);

        obs.delete(); rr_toggle = 1'b1;
        ar(4'd1, 32'h4000_0000, 8'd3, 3'd2, 2'd1);
        drain(); rr_toggle = 1'b0;
        chk("incr_n", obs.size(), 4);
        chk("incr_d0", obs[0].data, 32'h1000_0000);
        chk("incr_d3", obs[3].data, 32'h1000_000C);
        chk("incr_last", {obs[3].last, obs[2].last, obs[1].last, obs[0].last}, 4'b1000);

        obs.delete();
        ar(4'd2, 32'h4000_0008, 8'd3, 3'd2, 2'd2);
        drain();
        chk("wrap_order", {obs[0].data[7:0], obs[1].data[7:0], obs[2].data[7:0], obs[3].data[7:0]},
            32'h080C_0004);

        obs.delete();
        ar(4'd4, 32'h4000_0008, 8'd2, 3'd2, 2'd2);
        drain();
        chk("wrap3_n", obs.size(), 3);
        chk("wrap3_resp", {obs[0].resp, obs[1].resp, obs[2].resp}, 6'b101010);

        obs.delete();
        ar(4'd5, 32'h4000_0FFC, 8'd1, 3'd2, 2'd1);
        drain();
        chk("oor_b0", {obs[0].data, obs[0].resp}, {32'hCAFE_F00D, 2'd0});
        chk("oor_b1", {obs[1].data, obs[1].resp}, {32'h0, 2'd3});

        obs.delete();
        ar(4'd6, 32'h4000_001C, 8'd2, 3'd2, 2'd0);
        drain();
        chk("fixed_n", obs.size(), 3);
        chk("fixed_d2", obs[2].data, 32'h1000_001C);

        obs.delete();
        ar(4'd7, 32'h4000_0000, 8'd1, 3'd3, 2'd1);
        drain();
        chk("oversize", {obs[0].resp, obs[1].resp, obs[1].data}, {2'd2, 2'd2, 32'h0});

        obs.delete();
        ar(4'd8, 32'h3FFF_FFFC, 8'd0, 3'd2, 2'd1);
        drain();
        chk("below_base", {obs[0].data, obs[0].resp}, {32'h0, 2'd3});

        obs.delete();
        ar(4'd1, 32'h4000_0000, 8'd7, 3'd2, 2'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_rvalid", rvalid, 0);
        chk("abort_arready0", arready, 0);
        @(posedge clk); #1;
        chk("abort_arready1", arready, 1);
        chk("abort_beats", obs.size(), 3);
        obs.delete();
        ar(4'd9, 32'h4000_0014, 8'd0, 3'd2, 2'd1);
        drain();
        chk("after_abort", {obs[0].id, obs[0].data}, {4'd9, 32'hDEAD_BEEF});

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_rd_mem.md
# axi_rd_mem

Parametrised AXI4 read-only memory slave that serves instruction fetches from the IFU read channels. It generalises the current single-beat instruction memory to configurable data width, depth, ID width and base address. It adds full FIXED/INCR/WRAP burst support, narrow transfers, R-channel backpressure and DECERR/SLVERR responses. It includes a word-wide preload port for boot images and testbenches.

## Interface
- Clock and reset: one clock; reset is synchronous and active-high.
- Parameters:
  - DATA_WIDTH, default 32: R data width; must be 32, 64 or 128.
  - ADDR_WIDTH, default 32: AR address width.
  - ID_WIDTH, default 4: AXI ID width.
  - DEPTH_WORDS, default 1024: memory depth in DATA_WIDTH words; must be a power of two.
  - BASE_ADDR, default 32'h4000_0000: first decoded byte address.
- Ports:
  - clk  in  1  clock.
  - rst  in  1  synchronous active-high reset.
  - axi_slv_arid  in  ID_WIDTH  request ID.
  - axi_slv_araddr  in  ADDR_WIDTH  start byte address.
  - axi_slv_arlen  in  8  beats minus 1.
  - axi_slv_arsize  in  3  log2 of bytes per beat.
  - axi_slv_arburst  in  2  burst type: 0 FIXED, 1 INCR, 2 WRAP.
  - axi_slv_arlock, arcache, arprot, arqos, arregion  in  1/4/3/4/4  accepted and ignored.
  - axi_slv_arvalid  in  1  request valid.
  - axi_slv_arready  out  1  request accept.
  - axi_slv_rid  out  ID_WIDTH  echoed ID.
  - axi_slv_rdata  out  DATA_WIDTH  read data.
  - axi_slv_rresp  out  2  0 OKAY, 2 SLVERR, 3 DECERR.
  - axi_slv_rlast  out  1  final beat.
  - axi_slv_rvalid  out  1  beat valid.
  - axi_slv_rready  in  1  master accept.
  - init_we  in  1  preload write strobe.
  - init_idx  in  log2(DEPTH_WORDS)  word index.
  - init_wdata  in  DATA_WIDTH  preload word.

## Operation
- FSM states:
  - IDLE: arready=1. On arvalid&&arready, latch id, addr, len, size, burst, clear the beat counter, issue the first read, and go to BURST.
  - BURST: arready=0. A beat is consumed when rvalid&&rready. Consuming a non-last beat computes the next address and issues the next read. Consuming the last beat (beat counter == len) goes to IDLE.
- Next address per burst type:
  - FIXED: address unchanged.
  - INCR: address + (1<<size). No 4KB-boundary checking.
  - WRAP: the container is (len+1)<<size bytes, aligned down. Increment within the container and wrap to its base.
- Word selection: word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). The full word is returned on every beat; narrow beats do not lane-shift, and the master selects bytes.
- Error responses:
  - DECERR: address outside [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*DATA_WIDTH/8). Evaluated per beat; that beat returns rdata=0 and rresp=3.
  - SLVERR: size > log2(DATA_WIDTH/8), burst==3, or WRAP with len not in {1,3,7,15}. Every beat of the burst returns rresp=2 and rdata=0; beat count is still len+1.
- rlast=1 exactly on beat index len.
- Preload port: init_we writes mem[init_idx] in that cycle. It is independent of AXI activity. If it collides with a read of the same word, the read returns the old word. Memory contents are not reset.

## Timing
- Reset values: arready=0, rvalid=0, rlast=0, rid=0, rresp=0, rdata=0. The FSM resets to IDLE; arready is 1 from the first cycle after rst deasserts.
- Latency: AR handshake at cycle T gives the first rvalid at T+1. Registered synchronous read; no combinational path from araddr to rdata.
- Throughput: one beat per cycle while rready=1. A burst of len+1 beats finishes its last handshake at T+1+len.
- Backpressure: when rvalid&&!rready, rdata, rresp, rlast and rid hold stable and no new read is issued.
- Turnaround: after the last-beat handshake, rvalid=0 and arready=1 in the next cycle. Minimum gap between AR handshakes is len+2 cycles.
- Reset mid-burst: the burst is aborted, and outputs take reset values on the next edge.

## Structure
- Shared package axi_pkg holds:
  - burst encodings AXI_BURST_FIXED/INCR/WRAP;
  - response codes AXI_RESP_OKAY/SLVERR/DECERR;
  - the width constants for len, size and burst, reused from the existing AXI defines.
- Sub-module axi_burst_addr_gen: combinational next-address calculator (addr, size, len, burst -> next_addr), reusable by a later write slave.
- The memory array is inferred inside axi_rd_mem; the target is 120-400 RTL lines total.

## Test plan
- Single beat: preload word 5 = 32'hDEAD_BEEF; AR addr 0x4000_0014, len=0, size=2, INCR, id=3 -> rvalid one cycle after AR with rdata DEADBEEF, rid=3, rresp=0, rlast=1.
- INCR burst with backpressure: len=3 from 0x4000_0000, rready toggled 1,0,1,0… -> words 0,1,2,3 in order, each stable while stalled, rlast only on the 4th beat.
- WRAP: len=3, size=2, addr 0x4000_0008 -> words 2,3,0,1. WRAP with len=2 -> 3 beats, all rresp=2.
- Out of range: len=1 from BASE+DEPTH_WORDS*4-4 -> beat 0 OKAY with the last word, beat 1 DECERR with rdata=0.
- FIXED burst and oversize: FIXED len=2 at word 7 -> word 7 three times. size=3 on a 32-bit bus -> SLVERR on every beat.
- Reset mid-burst: assert rst on beat 2 of a len=7 burst -> rvalid=0 next cycle, arready=1 the cycle after rst falls, and a new request completes normally.
